// File: rtl/instr_enc.sv
// RV32I instruction encoder: packs instruction fields into a 32-bit word and buffers it in a 2-entry FIFO.
// Optional build macro INSTR_ENC_RANGE_CHECK_EN adds err_range and rejects immediates that do not fit their format.
module instr_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_cls,
  input  logic [2:0]  in_funct3,
  input  logic        in_f7b5,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_illegal,
  output logic [15:0] emit_cnt,
`ifdef INSTR_ENC_RANGE_CHECK_EN
  output logic        err_range,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_STORE  = 3'd1;
  localparam logic [2:0] CLS_RTYPE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_ITYPE  = 3'd4;
  localparam logic [2:0] CLS_JAL    = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  fifo_state_e state_q, state_d;
  logic [31:0] head_q, head_d;
  logic [31:0] tail_q, tail_d;
  logic [15:0] emit_cnt_q, emit_cnt_d;
  logic        err_illegal_q, err_illegal_d;

  logic [31:0] enc_word;
  logic        cls_legal;
  logic        accept;
  logic        push;
  logic        pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid must not wait on ready. An accepted request with an
  // illegal class (or out-of-range immediate) completes but stores nothing.
  assign in_ready  = !rst && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    enc_word  = '0;
    cls_legal = 1'b1;
    case (in_cls)
      CLS_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      CLS_ITYPE:  enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
      CLS_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:0], OP_STORE};
      CLS_RTYPE:  enc_word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1,
                              in_funct3, in_rd, OP_REG};
      CLS_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                              in_funct3, in_imm[4:1], in_imm[11], OP_BRANCH};
      CLS_JAL:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11],
                              in_imm[19:12], in_rd, OP_JAL};
      default:    cls_legal = 1'b0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic range_ok;
  logic fits_i, fits_b, fits_j;
  logic err_range_q, err_range_d;

  // A value fits an N-bit signed field when all bits above N-2 equal the sign.
  assign fits_i = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fits_b = !in_imm[0] && ((&in_imm[31:12]) || !(|in_imm[31:12]));
  assign fits_j = !in_imm[0] && ((&in_imm[31:20]) || !(|in_imm[31:20]));

  always_comb begin
    range_ok = 1'b1;
    case (in_cls)
      CLS_LOAD, CLS_ITYPE, CLS_STORE: range_ok = fits_i;
      CLS_BRANCH:                     range_ok = fits_b;
      CLS_JAL:                        range_ok = fits_j;
      default:                        range_ok = 1'b1;
    endcase
  end

  assign push        = accept && cls_legal && range_ok;
  assign err_range_d = accept && cls_legal && !range_ok;
  assign err_range   = err_range_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_range_q <= 1'b0;
    end else begin
      err_range_q <= err_range_d;
    end
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:21];
  assign push          = accept && cls_legal;
`endif

  assign err_illegal_d = accept && !cls_legal;
  assign emit_cnt_d    = pop ? emit_cnt_q + 16'd1 : emit_cnt_q;

  // The head register always feeds out_instr, so it only changes on a pop or
  // on a push into an empty FIFO; that keeps the word stable under backpressure.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = enc_word;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = enc_word;
            state_d = FULL;
          end
          2'b01: state_d = EMPTY;
          2'b11: head_d  = enc_word;
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      head_q        <= '0;
      tail_q        <= '0;
      emit_cnt_q    <= '0;
      err_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      emit_cnt_q    <= emit_cnt_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  assign out_instr   = head_q;
  assign emit_cnt    = emit_cnt_q;
  assign err_illegal = err_illegal_q;
  assign dbg_state   = state_q;

endmodule
